// File: rtl/stage_burn_pkg.sv
// stage_burn_pkg: shared FSM encoding and default widths for the stage burn controller
package stage_burn_pkg;
  localparam int N_DEF  = 64;
  localparam int TW_DEF = 16;
  typedef enum logic [1:0] {IDLE, DIV, BURN, DONE} state_t;
endpackage

// File: rtl/serial_divider.sv
// serial_divider: restoring unsigned divider, one quotient bit per cycle, result N cycles after start
module serial_divider
  import stage_burn_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         CLK,
  input  logic         RESETB,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] quo,
  output logic [N-1:0] rem
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] cnt;
  logic [N-1:0] div_q, r_in, q_in, d_in, r_n, q_n;
  logic [N:0] sh;
  logic ge;
  // start performs the first step on fresh operands, so the last of N steps lands N-1 edges later
  always_comb begin
    r_in = start ? '0 : rem;
    q_in = start ? a : quo;
    d_in = start ? b : div_q;
    sh   = {r_in, q_in[N-1]};
    ge   = sh >= {1'b0, d_in};
    r_n  = ge ? sh[N-1:0] - d_in : sh[N-1:0];
    q_n  = {q_in[N-2:0], ge};
  end
  // shift/subtract iteration and done pulse issued with the final quotient bit
  always_ff @(posedge CLK or negedge RESETB)
    if (!RESETB) begin
      cnt   <= '0;
      done  <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      div_q <= '0;
    end else begin
      done <= !start && cnt == CW'(1);
      cnt  <= start ? CW'(N - 1) : (cnt != '0 ? cnt - CW'(1) : cnt);
      if (start || cnt != '0) begin
        rem   <= r_n;
        quo   <= q_n;
        div_q <= d_in;
      end
    end
endmodule

// File: rtl/stage_burn_controller.sv
// stage_burn_controller: sequences one rocket stage burn (divide, tick-driven mass depletion, end pulse)
// Optional macro BURN_REMAINDER_EN: final normal tick absorbs the division remainder so cur_mass ends at init - prop.
module stage_burn_controller
  import stage_burn_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          CLK,
  input  logic          RESETB,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_init_mass,
  input  logic [N-1:0]  cfg_prop_mass,
  input  logic [TW-1:0] cfg_burn_time,
  input  logic          tick,
  input  logic          abort,
  output logic          burning,
  output logic [N-1:0]  cur_mass,
  output logic [N-1:0]  mass_flow,
  output logic [TW-1:0] elapsed,
  output logic          ignition_end,
  output logic          cfg_err,
  output logic [2:0]    stage_count
);
  state_t state, state_n;
  logic [TW-1:0] burn_time_l;
  logic [N-1:0] div_quo, div_rem, rem_adj;
  logic go, rej, acc, div_start, div_done, last_tick;
  assign go        = state == IDLE && cfg_valid && cfg_ready;
  assign rej       = go && cfg_prop_mass > cfg_init_mass;
  assign acc       = go && !rej;
  assign div_start = acc && cfg_burn_time != '0;
  assign last_tick = tick && elapsed + TW'(1) == burn_time_l;
  assign burning   = state == BURN;
`ifdef BURN_REMAINDER_EN
  assign rem_adj = div_rem;
`else
  logic unused_rem;
  assign rem_adj    = '0;
  assign unused_rem = ^div_rem;
`endif
  serial_divider #(.N(N)) u_div (
    .CLK    (CLK),
    .RESETB (RESETB),
    .start  (div_start),
    .a      (cfg_prop_mass),
    .b      ({{(N-TW){1'b0}}, cfg_burn_time}),
    .done   (div_done),
    .quo    (div_quo),
    .rem    (div_rem)
  );
  // state register
  always_ff @(posedge CLK or negedge RESETB)
    if (!RESETB) state <= IDLE;
    else state <= state_n;
  // next state: abort wins over tick and divider completion
  always_comb begin
    state_n = state == IDLE ? (acc ? (cfg_burn_time == '0 ? DONE : DIV) : IDLE)
            : state == DIV  ? (abort ? DONE : (div_done ? BURN : DIV))
            : state == BURN ? (abort || last_tick ? DONE : BURN)
            : IDLE;
  end
  // datapath, handshake and pulse registers
  always_ff @(posedge CLK or negedge RESETB)
    if (!RESETB) begin
      cfg_ready    <= 1'b0;
      cfg_err      <= 1'b0;
      ignition_end <= 1'b0;
      stage_count  <= '0;
      burn_time_l  <= '0;
      cur_mass     <= '0;
      mass_flow    <= '0;
      elapsed      <= '0;
    end else begin
      cfg_ready    <= state_n == IDLE;
      cfg_err      <= rej;
      ignition_end <= state == DONE;
      if (state == DONE) stage_count <= stage_count + 3'd1;
      if (acc) begin
        burn_time_l <= cfg_burn_time;
        elapsed     <= '0;
        mass_flow   <= '0;
        cur_mass    <= cfg_burn_time == '0 ? cfg_init_mass - cfg_prop_mass : cfg_init_mass;
      end
      if (state == DIV && !abort && div_done) mass_flow <= div_quo;
      if (state == BURN && !abort && tick) begin
        elapsed  <= elapsed + TW'(1);
        cur_mass <= cur_mass - mass_flow - (last_tick ? rem_adj : '0);
      end
    end
endmodule

// File: doc/stage_burn_controller.md
STAGE_BURN_CONTROLLER -- requirements
Module: stage_burn_controller

Interface
REQ-001 SHALL have parameters: N, 64, mass/flow datapath width; TW, 16, burn-time/elapsed width (seconds).
REQ-002 SHALL have ports: CLK  in  1  clock, rising edge; RESETB  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cfg_valid  in  1  stage parameters offered; cfg_ready  out  1  controller accepts parameters.
REQ-004 SHALL have ports: cfg_init_mass  in  N  vehicle mass at ignition (kg); cfg_prop_mass  in  N  stage propellant (kg); cfg_burn_time  in  TW  burn duration (s).
REQ-005 SHALL have ports: tick  in  1  one-second strobe; abort  in  1  cut-off request.
REQ-006 SHALL have ports: burning  out  1  engine lit; cur_mass  out  N  current vehicle mass; mass_flow  out  N  kg per tick; elapsed  out  TW  seconds burned.
REQ-007 SHALL have ports: ignition_end  out  1  one-cycle end-of-burn pulse; cfg_err  out  1  one-cycle reject pulse; stage_count  out  3  completed burns.

Function
REQ-008 SHALL use states IDLE, DIV, BURN, DONE; cfg_ready = 1 only in IDLE.
REQ-009 SHALL accept on cfg_valid & cfg_ready: latch all cfg_* inputs, set cur_mass = cfg_init_mass, elapsed = 0.
REQ-010 SHALL reject when cfg_prop_mass > cfg_init_mass: pulse cfg_err next cycle, latch nothing, stay IDLE.
REQ-011 SHALL, on accept with cfg_burn_time == 0, go directly to DONE and set cur_mass = init - prop, mass_flow = 0.
REQ-012 SHALL otherwise enter DIV and compute mass_flow = floor(prop / burn_time) and remainder in exactly N cycles; then enter BURN.
REQ-013 SHALL ignore tick outside BURN, including during DIV.
REQ-014 SHALL assert burning only in BURN.
REQ-015 SHALL, on each tick in BURN, do elapsed += 1 and cur_mass -= mass_flow in the same cycle.
REQ-016 SHALL enter DONE on the tick where elapsed becomes burn_time.
REQ-017 SHALL, in DONE, assert ignition_end for exactly one cycle, increment stage_count (wrap 7 -> 0), and return to IDLE next cycle.
REQ-018 SHALL treat abort in DIV or BURN as an early end: go to DONE with cur_mass and elapsed frozen at current values; abort has priority over a simultaneous tick.
REQ-019 SHALL ignore abort in IDLE and in DONE.
REQ-020 SHALL hold cur_mass, mass_flow and elapsed in IDLE until the next accept.
REQ-021 SHALL perform all mass arithmetic unsigned N-bit; underflow cannot occur given REQ-010.

Reset
REQ-022 SHALL, with RESETB low, set: state IDLE; cfg_ready 0 (1 once in IDLE after release); burning 0; ignition_end 0; cfg_err 0; cur_mass 0; mass_flow 0; elapsed 0; stage_count 0.
REQ-023 SHALL, on reset asserted mid-DIV or mid-BURN, discard the burn with no ignition_end pulse.

Configuration
REQ-024 SHALL honour macro BURN_REMAINDER_EN:
- defined: on the final normal tick (not abort), cur_mass = init - prop exactly, absorbing the division remainder.
- undefined: cur_mass = init - mass_flow*burn_time, leaving the truncation residue.

Structure
REQ-025 SHALL place state encoding and default N/TW constants in shared package stage_burn_pkg.
REQ-026 SHALL implement division in sub-module serial_divider: restoring, 1 bit/cycle, start/done handshake, N-cycle latency.

Verification
REQ-027 Accept init 2875403, prop 2077000, burn 168 -> mass_flow 12363 after 64 cycles; after 168 ticks cur_mass 798403 (EN) / 798419 (no EN); one ignition_end; stage_count 1.
REQ-028 Prop 100 > init 50 -> cfg_err pulse, state IDLE, outputs unchanged.
REQ-029 Burn_time 0, init 1000, prop 400 -> ignition_end two cycles after accept; cur_mass 600.
REQ-030 Abort coincident with tick 10 of a 168 s burn -> elapsed 9, cur_mass = init - 9*flow, single ignition_end.
REQ-031 Ticks during DIV, plus cfg_valid held through BURN -> neither has any effect; the next accept occurs only in IDLE.
REQ-032 Eight back-to-back burns -> stage_count wraps to 0; RESETB pulse mid-BURN -> all outputs per REQ-022 and no pulse.
